regfile_wr_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: A (ALU result) and B (memory load).
- Arbitrates round-robin and registers the winning request in a one-entry output stage.
- Drives the 32-bit one-hot write-enable bus, decoded from the 5-bit register number, plus the write data.
- Sits between the writeback stage and the 32x32 register file; honours a stall input from the register file.

---
 rtl/regfile_wr_arbiter_pkg.sv | 28 ++
 rtl/regfile_wr_arbiter_if.sv | 43 ++++
 rtl/regfile_wr_arbiter_chk.sv | 37 +++
 rtl/regfile_wr_arbiter_decoder.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the register-file write-port arbiter.
//   REG_NO_W / NUM_REGS : geometry of the 32x32 register file
//   grant_e             : which requester won the last completed transfer
//   ostate_e            : occupancy of the one-entry output stage
//   reg_is_zero()       : writes to register 0 are counted, never performed
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int REG_NO_W = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_e;

   function automatic logic reg_is_zero(input logic [REG_NO_W-1:0] reg_no);
      return (reg_no == {REG_NO_W{1'b0}});
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles both writeback requesters and the register-file write port.
//   master : requester / register-file side (drives valid, reg_no, data, stall)
//   slave  : the arbiter (drives ready, wr_en, wr_data, busy, drop_cnt)
// ----------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
);
   import regfile_pkg::*;

   logic                a_valid;
   logic                a_ready;
   logic [REG_NO_W-1:0] a_reg_no;
   logic [DATA_W-1:0]   a_data;

   logic                b_valid;
   logic                b_ready;
   logic [REG_NO_W-1:0] b_reg_no;
   logic [DATA_W-1:0]   b_data;

   logic                wr_stall;
   logic [NUM_REGS-1:0] wr_en;
   logic [DATA_W-1:0]   wr_data;
   logic                busy;
   logic [CNT_W-1:0]    drop_cnt;

   modport master (
      output a_valid, a_reg_no, a_data,
      output b_valid, b_reg_no, b_data,
      output wr_stall,
      input  a_ready, b_ready, wr_en, wr_data, busy, drop_cnt
   );

   modport slave (
      input  a_valid, a_reg_no, a_data,
      input  b_valid, b_reg_no, b_data,
      input  wr_stall,
      output a_ready, b_ready, wr_en, wr_data, busy, drop_cnt
   );

endinterface

// File: rtl/regfile_wr_arbiter_chk.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_chk
// Property checker for the write-port arbiter; instantiated by the top.
//   clk, rst_n        : clock and synchronous active-low reset
//   a_ready, b_ready  : requester handshakes
//   wr_stall, busy    : register-file stall and output-stage occupancy
//   wr_en             : one-hot write enable
// ----------------------------------------------------------------------------
module regfile_wr_arbiter_chk #(
   parameter int NUM_REGS = 32
) (
   input logic                clk,
   input logic                rst_n,
   input logic                a_ready,
   input logic                b_ready,
   input logic                wr_stall,
   input logic                busy,
   input logic [NUM_REGS-1:0] wr_en
);

   // The register file must never see two enables at once.
   wr_en_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(wr_en));

   // A single write port can accept only one requester per cycle.
   ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(a_ready && b_ready));

   // An occupied output stage always presents its write.
   busy_matches_en: assert property (@(posedge clk) disable iff (!rst_n)
      busy == (wr_en != {NUM_REGS{1'b0}}));

   // A stalled write is held unchanged into the next cycle.
   stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
      (busy && wr_stall) |=> (busy && $stable(wr_en)));

endmodule

// File: rtl/regfile_wr_arbiter_decoder.sv
// ----------------------------------------------------------------------------
// decoder5_32
// Plain 5-to-32 one-hot register decoder.
//   sel : register number
//   dec : one-hot select, bit sel set
// ----------------------------------------------------------------------------
module decoder5_32 (
   input  logic [4:0]  sel,
   output logic [31:0] dec
);

   // One-hot decode of the register number.
   always_comb begin
      dec      = 32'h0000_0000;
      dec[sel] = 1'b1;
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the register file's single write port between requester A (ALU
// writeback) and requester B (memory load). A round-robin grant picks one
// request per cycle; the winner is registered in a one-entry output stage
// that drives the one-hot write enable and write data. Writes to register 0
// complete their handshake but are dropped and counted.
//
// Ports:
//   clk    : system clock, all state on rising edge
//   rst_n  : synchronous active-low reset; also forces both readies low
//   bus    : slave modport of regfile_wr_arbiter_if
//            (a_*/b_* handshakes, wr_stall in; wr_en, wr_data, busy,
//             drop_cnt out)
// ----------------------------------------------------------------------------
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   regfile_wr_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ostate_e             state_r;
   grant_e              last_grant_r;
   logic [REG_NO_W-1:0] reg_no_r;
   logic [DATA_W-1:0]   data_r;
   logic [CNT_W-1:0]    drop_cnt_r;

   logic                out_valid_s;
   logic                room_s;
   logic                gnt_a_s;
   logic                gnt_b_s;
   logic                a_ready_s;
   logic                b_ready_s;
   logic                xfer_a_s;
   logic                xfer_b_s;
   logic                xfer_s;
   logic                xfer_zero_s;
   logic [REG_NO_W-1:0] in_reg_no_s;
   logic [DATA_W-1:0]   in_data_s;
   logic [NUM_REGS-1:0] dec_s;
   logic [NUM_REGS-1:0] wr_en_s;

   // Round-robin grant: on contention the requester that did not win last.
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      case ({bus.a_valid, bus.b_valid})
         2'b10: gnt_a_s = 1'b1;
         2'b01: gnt_b_s = 1'b1;
         2'b11: begin
            if (last_grant_r == GNT_B) begin
               gnt_a_s = 1'b1;
            end else begin
               gnt_b_s = 1'b1;
            end
         end
         default: begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
         end
      endcase
   end

   // Handshake: the stage can take a new write when empty or when its held
   // write commits this cycle. Ready never looks at reg_no or data.
   always_comb begin
      out_valid_s = (state_r == FULL);
      room_s      = rst_n && (!out_valid_s || !bus.wr_stall);
      a_ready_s   = gnt_a_s && room_s;
      b_ready_s   = gnt_b_s && room_s;
      xfer_a_s    = bus.a_valid && a_ready_s;
      xfer_b_s    = bus.b_valid && b_ready_s;
      xfer_s      = xfer_a_s || xfer_b_s;
      if (xfer_b_s) begin
         in_reg_no_s = bus.b_reg_no;
         in_data_s   = bus.b_data;
      end else begin
         in_reg_no_s = bus.a_reg_no;
         in_data_s   = bus.a_data;
      end
      xfer_zero_s = xfer_s && reg_is_zero(in_reg_no_s);
   end

   // Output-stage FSM with its stored write, grant history and drop counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= EMPTY;
         last_grant_r <= GNT_B;
         reg_no_r     <= {REG_NO_W{1'b0}};
         data_r       <= {DATA_W{1'b0}};
         drop_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (xfer_a_s) begin
            last_grant_r <= GNT_A;
         end else if (xfer_b_s) begin
            last_grant_r <= GNT_B;
         end else begin
            last_grant_r <= last_grant_r;
         end

         case (state_r)
            EMPTY: begin
               if (xfer_s && !xfer_zero_s) begin
                  state_r  <= FULL;
                  reg_no_r <= in_reg_no_s;
                  data_r   <= in_data_s;
               end else begin
                  state_r  <= EMPTY;
               end
            end
            FULL: begin
               // Stalled: nothing transfers (room_s is low), write is held.
               if (!bus.wr_stall) begin
                  if (xfer_s && !xfer_zero_s) begin
                     state_r  <= FULL;
                     reg_no_r <= in_reg_no_s;
                     data_r   <= in_data_s;
                  end else begin
                     state_r  <= EMPTY;
                  end
               end else begin
                  state_r <= FULL;
               end
            end
            default: begin
               state_r <= EMPTY;
            end
         endcase

         if (xfer_zero_s && (drop_cnt_r != CNT_MAX)) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
      end
   end

   decoder5_32 u_dec (
      .sel (reg_no_r),
      .dec (dec_s)
   );

   // Enable only while a write is held; gating with rst_n keeps a write held
   // across a reset edge from ever reaching the register file.
   always_comb begin
      if (out_valid_s && rst_n) begin
         wr_en_s = dec_s;
      end else begin
         wr_en_s = {NUM_REGS{1'b0}};
      end
   end

   assign bus.a_ready  = a_ready_s;
   assign bus.b_ready  = b_ready_s;
   assign bus.wr_en    = wr_en_s;
   assign bus.wr_data  = data_r;
   assign bus.busy     = out_valid_s;
   assign bus.drop_cnt = drop_cnt_r;

   regfile_wr_arbiter_chk #(
      .NUM_REGS (NUM_REGS)
   ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_ready  (a_ready_s),
      .b_ready  (b_ready_s),
      .wr_stall (bus.wr_stall),
      .busy     (out_valid_s),
      .wr_en    (wr_en_s)
   );

endmodule
